uart_rx_param: RTL
==================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 8: sample ticks per bit, even, at least 4.
REQ-003 SHALL have parameter CLKS_PER_TICK, default 5: clk cycles per sample tick, at least 1.
REQ-004 SHALL have parameter PARITY_MODE, default 2: 0 = none, 1 = even, 2 = odd.
REQ-005 SHALL have parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge clk.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port in, input, 1 bit: serial line, idle high, asynchronous to clk.
REQ-009 SHALL have port ready, input, 1 bit: the consumer accepts the held word.
REQ-010 SHALL have port data_out, output, DATA_BITS bits: received word, LSB = first bit received.
REQ-011 SHALL have port valid, output, 1 bit: data_out and the flags are held for the consumer.
REQ-012 SHALL have port parity_err, output, 1 bit: held word failed the parity check.
REQ-013 SHALL have port frame_err, output, 1 bit: a stop bit of the held word sampled low.
REQ-014 SHALL have port overrun, output, 1 bit: an unaccepted word was overwritten.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-016 SHALL synchronise in through two flops (rx_s) before any use; the two-cycle latency is accepted.
REQ-017 Tick generator SHALL count 1..CLKS_PER_TICK and assert tick for exactly one clk when the count equals CLKS_PER_TICK, then restart at 1.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; all FSM transitions and sample counting SHALL occur only on tick cycles.
REQ-019 Sample counter s SHALL run 1..OVERSAMPLE within each bit; the "mid-sample" is s == OVERSAMPLE/2.
REQ-020 IDLE: on a tick with rx_s == 0, go to START with s = 1.
REQ-021 START: at mid-sample with rx_s == 1 (false start), return to IDLE.
REQ-022 START: when s reaches OVERSAMPLE, go to DATA with bit index 0.
REQ-023 DATA: at mid-sample, shift rx_s into bit[index].
REQ-024 DATA: after the DATA_BITS-th bit completes, go to PARITY if PARITY_MODE != 0, otherwise to STOP.
REQ-025 PARITY: at mid-sample, compare rx_s with the expected bit. Even mode expects XOR(data). Odd mode expects ~XOR(data). A mismatch sets an internal perr.
REQ-026 STOP: at mid-sample of each stop bit, set an internal ferr if rx_s == 0.
REQ-027 STOP: at mid-sample of the last stop bit, commit the frame and return to IDLE immediately, so back-to-back frames are supported.
REQ-028 Commit SHALL load data_out, parity_err = perr, and frame_err = ferr, and set valid = 1, on the clk following the committing tick. Errored frames SHALL be delivered with their flags set.
REQ-029 Handshake: a transfer occurs on a clk where valid and ready are both 1. After a transfer with no commit in the same cycle, valid SHALL be 0 and overrun SHALL be 0 on the next clk.
REQ-030 Commit while valid == 1 and ready == 0 SHALL overwrite data_out and the error flags, keep valid at 1, and set overrun to 1.
REQ-031 overrun SHALL hold until the word it accompanies is transferred.
REQ-032 Commit in the same cycle as a transfer SHALL load the new word with valid = 1 and overrun = 0.
REQ-033 perr and ferr SHALL clear on each entry to START.
REQ-034 A parity bit SHALL never be sampled when PARITY_MODE == 0.

Reset
REQ-035 Asserting reset at any time, including mid-frame, SHALL immediately force:
- FSM to IDLE;
- s to 1, the tick counter to 1, the synchroniser flops to 1;
- data_out to 0;
- valid, parity_err, frame_err, overrun, busy to 0.
REQ-036 After reset deasserts, the first tick SHALL occur CLKS_PER_TICK clks later. A line already low SHALL be treated as a start edge.

Verification
All scenarios use default parameters: bit period = 40 clk, odd parity.
REQ-037 Frame 0xA5, odd parity bit 1, stop 1, ready held 1 -> data_out = 0xA5 and a one-clk valid pulse; parity_err = frame_err = overrun = 0.
REQ-038 Frame 0x3C with its parity bit inverted -> valid = 1, data_out = 0x3C, parity_err = 1.
REQ-039 Frame 0x81 with the stop bit driven 0 -> valid = 1, frame_err = 1; a following 0x7E frame sent with a one-bit idle gap -> data_out = 0x7E, frame_err = 0.
REQ-040 Low glitch of 12 clk on an idle line -> false start; busy returns to 0 and valid stays 0.
REQ-041 Frames 0x11 then 0x22 back-to-back with ready = 0 -> data_out = 0x22, valid = 1, overrun = 1. Pulsing ready = 1 for one clk -> valid = 0 and overrun = 0.
REQ-042 Reset asserted during bit 4 of 0x55, then a clean frame 0x96 -> all outputs 0 during reset; then data_out = 0x96, no error flags.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with configurable word length,
// parity and stop bits. Serial input is synchronised, sampled at the middle
// of each bit, and delivered through a valid/ready holding register with
// parity, framing and overrun flags.
module uart_rx_param #(
  parameter int DATA_BITS     = 8,
  parameter int OVERSAMPLE    = 8,
  parameter int CLKS_PER_TICK = 5,
  parameter int PARITY_MODE   = 2,
  parameter int STOP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW  = $clog2(CLKS_PER_TICK + 1);
  localparam int SW  = $clog2(OVERSAMPLE + 1);
  localparam int IW  = $clog2(DATA_BITS);
  localparam int MID = OVERSAMPLE / 2;

  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [TW-1:0] T_MAX   = TW'(CLKS_PER_TICK);
  localparam logic [SW-1:0] S_ONE   = SW'(1);
  localparam logic [SW-1:0] S_MID   = SW'(MID);
  localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE);
  localparam logic [IW-1:0] I_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Synchroniser
  logic sync1_q, rx_s_q;

  // Tick generator and receive state
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic                 tick;
  state_t               state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  // Holding register seen by the consumer
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;

  logic commit;
  logic mid;
  logic last;
  logic exp_par;
  logic xfer;

  assign tick    = (tcnt_q == T_MAX);
  assign mid     = (s_q == S_MID);
  assign last    = (s_q == S_LAST);
  assign exp_par = (PARITY_MODE == 1) ? (^shreg_q) : ~(^shreg_q);
  assign xfer    = valid_q & ready;

  // Two-flop synchroniser on the asynchronous serial line (idles high)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= in;
      rx_s_q  <= sync1_q;
    end
  end

  // Next-state logic: tick counter, bit-level FSM, and handshake register
  always_comb begin
    tcnt_d  = tick ? T_ONE : tcnt_q + T_ONE;
    state_d = state_q;
    s_d     = s_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    commit  = 1'b0;

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d = START;
            s_d     = S_ONE;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
        START: begin
          if (mid && rx_s_q) begin
            // Line went back high before mid-bit: treat as noise
            state_d = IDLE;
            s_d     = S_ONE;
          end else if (last) begin
            state_d = DATA;
            s_d     = S_ONE;
            idx_d   = '0;
          end else begin
            s_d = s_q + S_ONE;
          end
        end
        DATA: begin
          if (mid) begin
            shreg_d[idx_q] = rx_s_q;
          end
          if (last) begin
            s_d = S_ONE;
            if (idx_q == I_LAST) begin
              state_d = (PARITY_MODE != 0) ? PARITY : STOP;
              stop_d  = 1'b0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            s_d = s_q + S_ONE;
          end
        end
        PARITY: begin
          if (mid) begin
            perr_d = (rx_s_q != exp_par);
          end
          if (last) begin
            state_d = STOP;
            s_d     = S_ONE;
            stop_d  = 1'b0;
          end else begin
            s_d = s_q + S_ONE;
          end
        end
        STOP: begin
          if (mid) begin
            if (!rx_s_q) begin
              ferr_d = 1'b1;
            end
            if (stop_q == STOP_LAST) begin
              // Commit at mid-stop so the next start edge can be caught
              commit  = 1'b1;
              state_d = IDLE;
              s_d     = S_ONE;
            end else begin
              s_d = s_q + S_ONE;
            end
          end else if (last) begin
            stop_d = stop_q + 1'b1;
            s_d    = S_ONE;
          end else begin
            s_d = s_q + S_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          s_d     = S_ONE;
        end
      endcase
    end

    dout_d  = dout_q;
    valid_d = valid_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
    if (commit) begin
      dout_d  = shreg_q;
      pe_d    = perr_d;
      fe_d    = ferr_d;
      valid_d = 1'b1;
      // Overwriting a word that is not being taken this cycle is an overrun
      ovr_d   = valid_q & ~ready;
    end else if (xfer) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_q  <= T_ONE;
      state_q <= IDLE;
      s_q     <= S_ONE;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      state_q <= state_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out   = dout_q;
  assign valid      = valid_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;

endmodule
